// File: rtl/mod_add_pkg.sv
// Shared constants and encodings for the modular add/subtract controller.
package mod_add_pkg;

  localparam int unsigned N = 1027;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    P1   = 3'd1,
    C1   = 3'd2,
    P2   = 3'd3,
    C2   = 3'd4,
    DONE = 3'd5
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/mod_add_ctrl_mpadder2.sv
// Shared carry-select adder with one register stage on the (W+1)-bit sum.
module mpadder2
  import mod_add_pkg::*;
#(
  parameter int unsigned W = N
) (
  input  logic         clk,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W:0]   s
);

  localparam int unsigned LO = W / 2;
  localparam int unsigned HI = W - LO;

  logic [LO:0] lo_sum;
  logic [HI:0] hi_sum0;
  logic [HI:0] hi_sum1;

  // Both upper-half candidates are formed in parallel; the low carry picks one.
  always_comb begin
    lo_sum  = {1'b0, a[LO-1:0]} + {1'b0, b[LO-1:0]};
    hi_sum0 = {1'b0, a[W-1:LO]} + {1'b0, b[W-1:LO]};
    hi_sum1 = hi_sum0 + (HI+1)'(1);
  end

  // Pipeline register; intentionally unreset, only read the cycle after a pass.
  always_ff @(posedge clk) begin
    s <= lo_sum[LO] ? {hi_sum1, lo_sum[LO-1:0]} : {hi_sum0, lo_sum[LO-1:0]};
  end

endmodule

// File: rtl/mod_add_ctrl.sv
// Two-pass modular add/subtract controller around one shared adder.
module mod_add_ctrl #(
  parameter int unsigned N = mod_add_pkg::N
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         start,
  input  logic         subtract,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic [N-1:0] in_m,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result
);

  import mod_add_pkg::*;

  state_t       state;
  logic [N-1:0] a_q;
  logic [N-1:0] b_q;
  logic [N-1:0] m_q;
  logic [N-1:0] t_q;
  logic         sub_q;
  logic         borrow_q;

  logic [N-1:0] add_a_c;
  logic [N-1:0] add_b_c;
  logic [N:0]   add_s;
  logic [N-1:0] pass1_c;
  logic [N-1:0] final_c;

  // Adder operand mux: pass 1 uses A/B, pass 2 uses T/M, zero otherwise.
  always_comb begin
    add_a_c = '0;
    add_b_c = '0;
    case (state)
      P1: begin
        add_a_c = (sub_q == OP_SUB) ? ~a_q : a_q;
        add_b_c = b_q;
      end
      P2: begin
        add_a_c = (sub_q == OP_SUB) ? t_q : ~t_q;
        add_b_c = m_q;
      end
      default: ;
    endcase
  end

  mpadder2 #(.W(N)) u_adder (
    .clk (clk),
    .a   (add_a_c),
    .b   (add_b_c),
    .s   (add_s)
  );

  // Pass-1 value (S or D) and pass-2 correction select.
  always_comb begin
    pass1_c = (sub_q == OP_SUB) ? ~add_s[N-1:0] : add_s[N-1:0];
    if (sub_q == OP_SUB) begin
      final_c = borrow_q ? add_s[N-1:0] : t_q;
    end else begin
      final_c = add_s[N] ? t_q : ~add_s[N-1:0];
    end
  end

  // Sequencer with registered busy/done/result and operand capture.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      m_q      <= '0;
      t_q      <= '0;
      sub_q    <= OP_ADD;
      borrow_q <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q   <= in_a;
            b_q   <= in_b;
            m_q   <= in_m;
            sub_q <= subtract;
            busy  <= 1'b1;
            state <= P1;
          end
        end
        P1: state <= C1;
        C1: begin
          t_q      <= pass1_c;
          borrow_q <= add_s[N];
          state    <= P2;
        end
        P2: state <= C2;
        C2: begin
          result <= final_c;
          done   <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_add_ctrl.sv
// Self-checking bench for mod_add_ctrl against an arithmetic reference model.
module tb_mod_add_ctrl;
  import mod_add_pkg::*;

  logic         clk;
  logic         resetn;
  logic         start;
  logic         subtract;
  logic [N-1:0] in_a;
  logic [N-1:0] in_b;
  logic [N-1:0] in_m;
  logic         busy;
  logic         done;
  logic [N-1:0] result;

  int total = 0;
  int bad   = 0;

  int           done_at[$];
  logic [N-1:0] res_at[$];
  int           busy_cnt;

  mod_add_ctrl #(.N(N)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .start    (start),
    .subtract (subtract),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_m     (in_m),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [N-1:0] rnd_vec();
    logic [1055:0] t;
    for (int i = 0; i < 33; i++) t[i*32 +: 32] = $urandom;
    return N'(t);
  endfunction

  // Reference: plain modular arithmetic on wide integers.
  function automatic logic [N-1:0] ref_mod(input logic sub, input logic [N-1:0] a,
                                           input logic [N-1:0] b, input logic [N-1:0] m);
    logic [N:0] s;
    if (sub == OP_SUB) s = {1'b0, a} + {1'b0, m} - {1'b0, b};
    else               s = {1'b0, a} + {1'b0, b};
    s = s % {1'b0, m};
    return N'(s);
  endfunction

  task automatic chk(input string tag, input logic [N:0] obs, input logic [N:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h required=%h", tag, obs[127:0], exp[127:0]);
    end
  endtask

  // Issue one start, optionally pulse a second start at cycle inj_k, watch ncyc cycles.
  task automatic run(input logic sub, input logic [N-1:0] a, input logic [N-1:0] b,
                     input logic [N-1:0] m, input int inj_k, input logic sub2,
                     input logic [N-1:0] a2, input logic [N-1:0] b2,
                     input logic [N-1:0] m2, input int ncyc);
    done_at.delete();
    res_at.delete();
    busy_cnt = 0;
    @(negedge clk);
    start = 1'b1; subtract = sub; in_a = a; in_b = b; in_m = m;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      if (done) begin
        done_at.push_back(k);
        res_at.push_back(result);
      end
      if (busy) busy_cnt++;
      if (k == inj_k) begin
        start = 1'b1; subtract = sub2; in_a = a2; in_b = b2; in_m = m2;
      end else begin
        start = 1'b0; subtract = 1'($urandom);
        in_a = rnd_vec(); in_b = rnd_vec(); in_m = rnd_vec();
      end
    end
    start = 1'b0;
  endtask

  task automatic run1(input logic sub, input logic [N-1:0] a, input logic [N-1:0] b,
                      input logic [N-1:0] m);
    run(sub, a, b, m, 0, OP_ADD, '0, '0, '0, 7);
  endtask

  logic [N-1:0] big_m;
  logic [N-1:0] ra, rb, rm, held;
  logic         rs;
  int           dcnt;

  initial begin
    resetn = 1'b0; start = 1'b0; subtract = 1'b0;
    in_a = '0; in_b = '0; in_m = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", (N+1)'(busy), '0);
    chk("reset_done", (N+1)'(done), '0);
    chk("reset_result", (N+1)'(result), '0);
    resetn = 1'b1;

    // First start after reset: 7+9 mod 13
    run1(OP_ADD, N'(7), N'(9), N'(13));
    chk("add_7_9_res", (N+1)'(res_at.size() > 0 ? res_at[0] : '1), (N+1)'(3));
    chk("add_done_lat", (N+1)'(done_at.size() > 0 ? done_at[0] : 0), (N+1)'(5));
    chk("add_done_cnt", (N+1)'(done_at.size()), (N+1)'(1));
    chk("add_busy_cnt", (N+1)'(busy_cnt), (N+1)'(5));
    chk("result_hold", (N+1)'(result), (N+1)'(3));

    run1(OP_SUB, N'(3), N'(9), N'(13));
    chk("sub_3_9", (N+1)'(result), (N+1)'(7));
    run1(OP_SUB, N'(5), N'(5), N'(13));
    chk("sub_5_5", (N+1)'(result), (N+1)'(0));
    run1(OP_ADD, N'(6), N'(7), N'(13));
    chk("add_s_eq_m", (N+1)'(result), (N+1)'(0));

    big_m = '0;
    big_m[1025:0] = '1;
    run1(OP_ADD, big_m - N'(1), big_m - N'(1), big_m);
    chk("big_add", (N+1)'(result), (N+1)'(big_m - N'(2)));
    run1(OP_SUB, N'(0), N'(1), big_m);
    chk("big_sub", (N+1)'(result), (N+1)'(big_m - N'(1)));

    // Second start during C1 must be ignored
    run(OP_ADD, N'(10), N'(8), N'(13), 2, OP_SUB, N'(1), N'(2), N'(11), 12);
    chk("c1_ign_cnt", (N+1)'(done_at.size()), (N+1)'(1));
    chk("c1_ign_res", (N+1)'(res_at.size() > 0 ? res_at[0] : '1), (N+1)'(5));

    // Back-to-back: start in the IDLE cycle right after DONE
    run(OP_ADD, N'(11), N'(12), N'(17), 6, OP_SUB, N'(2), N'(9), N'(17), 12);
    chk("b2b_cnt", (N+1)'(done_at.size()), (N+1)'(2));
    chk("b2b_k1", (N+1)'(done_at.size() > 0 ? done_at[0] : 0), (N+1)'(5));
    chk("b2b_k2", (N+1)'(done_at.size() > 1 ? done_at[1] : 0), (N+1)'(11));
    chk("b2b_r1", (N+1)'(res_at.size() > 0 ? res_at[0] : '1), (N+1)'(6));
    chk("b2b_r2", (N+1)'(res_at.size() > 1 ? res_at[1] : '1), (N+1)'(10));

    // Reset asserted during P2 aborts the operation
    @(negedge clk);
    start = 1'b1; subtract = OP_ADD; in_a = N'(4); in_b = N'(5); in_m = N'(13);
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("rst_mid_busy", (N+1)'(busy), '0);
    chk("rst_mid_done", (N+1)'(done), '0);
    chk("rst_mid_res", (N+1)'(result), '0);
    dcnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done) dcnt++;
      if (k == 2) resetn = 1'b1;
    end
    chk("rst_no_done", (N+1)'(dcnt), '0);
    run1(OP_ADD, N'(1), N'(1), N'(13));
    chk("post_rst_add", (N+1)'(result), (N+1)'(2));

    // Random operations versus the reference model
    for (int i = 0; i < 30; i++) begin
      rm = rnd_vec() >> $urandom_range(1, (i < 15) ? 20 : 1020);
      if (rm < N'(2)) rm = N'(2);
      ra = rnd_vec() % rm;
      rb = rnd_vec() % rm;
      rs = 1'($urandom);
      run1(rs, ra, rb, rm);
      chk($sformatf("rand%0d_res", i), (N+1)'(result), (N+1)'(ref_mod(rs, ra, rb, rm)));
      chk($sformatf("rand%0d_cnt", i), (N+1)'(done_at.size()), (N+1)'(1));
    end

    held = ref_mod(rs, ra, rb, rm);
    repeat (4) @(negedge clk);
    chk("final_hold", (N+1)'(result), (N+1)'(held));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
